// File: rtl/ff_cmd_driver.sv
// ff_cmd_driver
//   Command-driven controller and checker for a set/reset flip-flop with an
//   active-low synchronous clock enable. Each accepted command drives the
//   flip-flop controls for exactly one clock. The block waits WAIT_CYCLES
//   cycles, samples Q/~Q, and returns the observed Q plus an error flag that
//   compares it against an internal expected-value model.
//
// Ports
//   clk, reset        : single clock, synchronous active-high reset
//   cmd_valid/ready   : command handshake, cmd_op 00 HOLD 01 RESET 10 SET 11 DISABLE
//   ff_set/ff_reset   : flip-flop set/reset drive
//   ff_clock_en       : flip-flop enable, 0 = enabled (1 when idle)
//   ff_result/not_res : flip-flop Q and ~Q being checked
//   rsp_valid/ready   : response handshake carrying rsp_q and rsp_err
//   known             : expected-value model holds a defined value
//   err_count         : saturating count of erroneous responses
module ff_cmd_driver #(
  parameter int WAIT_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  output logic             ff_set,
  output logic             ff_reset,
  output logic             ff_clock_en,
  input  logic             ff_result,
  input  logic             ff_not_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_q,
  output logic             rsp_err,
  output logic             known,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [1:0] OP_HOLD    = 2'b00;
  localparam logic [1:0] OP_RESET   = 2'b01;
  localparam logic [1:0] OP_SET     = 2'b10;
  localparam logic [1:0] OP_DISABLE = 2'b11;

  // SETTLE covers WAIT_CYCLES-1 cycles; this is the counter value of its last one.
  localparam logic [3:0] SETTLE_LAST = 4'((WAIT_CYCLES > 1) ? (WAIT_CYCLES - 2) : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_RESP
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       op_reg;
  logic [3:0]       settle_cnt_reg;
  logic             exp_q_reg;
  logic             known_reg;
  logic             q_reg;
  logic             err_reg;
  logic [CNT_W-1:0] err_count_reg;

  // Sample evaluation, only consumed in CHECK.
  logic comp;
  logic exp_post;
  logic chk_err;

  always_comb begin
    comp = ff_result ^ ff_not_result;
    case (op_reg)
      OP_SET:   exp_post = 1'b1;
      OP_RESET: exp_post = 1'b0;
      default:  exp_post = exp_q_reg;
    endcase
    // Only a model that was defined before this command may flag a Q mismatch.
    chk_err = !comp || (known_reg && (ff_result != exp_post));
  end

  always_comb begin
    state_next  = state_reg;
    cmd_ready   = 1'b0;
    ff_set      = 1'b0;
    ff_reset    = 1'b0;
    ff_clock_en = 1'b1;
    rsp_valid   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = S_DRIVE;
      end
      S_DRIVE: begin
        case (op_reg)
          OP_HOLD: begin
            ff_clock_en = 1'b0;
          end
          OP_RESET: begin
            ff_clock_en = 1'b0;
            ff_reset    = 1'b1;
          end
          OP_SET: begin
            ff_clock_en = 1'b0;
            ff_set      = 1'b1;
          end
          OP_DISABLE: begin
            // Both controls asserted with the flip-flop disabled: it must ignore them.
            ff_set   = 1'b1;
            ff_reset = 1'b1;
          end
          default: ;
        endcase
        state_next = (WAIT_CYCLES > 1) ? S_SETTLE : S_CHECK;
      end
      S_SETTLE: begin
        if (settle_cnt_reg == SETTLE_LAST) state_next = S_CHECK;
      end
      S_CHECK: begin
        state_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Response fields read as zero outside RESP.
  assign rsp_q     = rsp_valid & q_reg;
  assign rsp_err   = rsp_valid & err_reg;
  assign known     = known_reg;
  assign err_count = err_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      op_reg         <= OP_HOLD;
      settle_cnt_reg <= '0;
      exp_q_reg      <= 1'b0;
      known_reg      <= 1'b0;
      q_reg          <= 1'b0;
      err_reg        <= 1'b0;
      err_count_reg  <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (cmd_valid) op_reg <= cmd_op;
        end
        S_DRIVE: begin
          settle_cnt_reg <= '0;
        end
        S_SETTLE: begin
          settle_cnt_reg <= settle_cnt_reg + 4'd1;
        end
        S_CHECK: begin
          q_reg   <= ff_result;
          err_reg <= chk_err;
          if (chk_err && !(&err_count_reg)) err_count_reg <= err_count_reg + CNT_W'(1);
          if ((op_reg == OP_SET) || (op_reg == OP_RESET)) begin
            // Explicit SET/RESET defines the model even if the sample was bad.
            exp_q_reg <= exp_post;
            known_reg <= 1'b1;
          end else if (!known_reg && !chk_err) begin
            // First clean sample after reset seeds the model.
            exp_q_reg <= ff_result;
            known_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ff_cmd_driver.md
# ff_cmd_driver

Command-driven controller and checker for the set/reset flip-flop with active-low synchronous clock enable. It accepts HOLD/SET/RESET/DISABLE commands over a valid/ready interface and drives the flip-flop's `set`, `reset` and `clock_en` inputs for exactly one clock. It then samples `result`/`not_result` and returns the observed state with an error flag over a second valid/ready interface. It sits between a test/stimulus source and the flip-flop, the writing end of the flip-flop's control interface.

## Interface

Parameters:
- `WAIT_CYCLES`, default 1: settle cycles between the drive cycle and the sample cycle; legal range 1..15.
- `CNT_W`, default 16: width of the saturating error counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset of this block.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_op`  in  2  opcode: 00 HOLD, 01 RESET, 10 SET, 11 DISABLE.
- `ff_set`  out  1  drives flip-flop `set`.
- `ff_reset`  out  1  drives flip-flop `reset`.
- `ff_clock_en`  out  1  drives flip-flop `clock_en`; 0 = enabled.
- `ff_result`  in  1  flip-flop Q.
- `ff_not_result`  in  1  flip-flop ~Q.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_q`  out  1  sampled `ff_result`.
- `rsp_err`  out  1  sampled state violates the expected model.
- `known`  out  1  the expected-value model holds a defined value.
- `err_count`  out  CNT_W  count of responses with `rsp_err`=1, saturating at all-ones.

## Operation

- Outputs at reset and when idle: `cmd_ready`=1, `ff_set`=0, `ff_reset`=0, `ff_clock_en`=1 (flip-flop disabled), `rsp_valid`=0, `rsp_q`=0, `rsp_err`=0, `known`=0, `err_count`=0.
- The FSM has five states, IDLE, DRIVE, SETTLE, CHECK and RESP:
  - IDLE: `cmd_ready`=1. On `cmd_valid`&`cmd_ready`, latch `cmd_op` and go to DRIVE.
  - DRIVE (1 cycle), with `cmd_ready`=0:
    - HOLD: `ff_clock_en`=0, set=0, reset=0.
    - RESET: `ff_clock_en`=0, reset=1.
    - SET: `ff_clock_en`=0, set=1.
    - DISABLE: `ff_clock_en`=1, set=1, reset=1. This checks that the disabled flip-flop ignores set/reset.
  - DRIVE then goes to SETTLE.
  - SETTLE: idle drive values, count WAIT_CYCLES-1 further cycles, then go to CHECK. With WAIT_CYCLES=1, SETTLE lasts 0 extra cycles and DRIVE goes straight to CHECK.
  - CHECK (1 cycle): sample `ff_result`/`ff_not_result` and compute `rsp_q`, `rsp_err` and the model update. Then go to RESP.
  - RESP: `rsp_valid`=1, with `rsp_q`/`rsp_err` stable. On `rsp_ready`, return to IDLE.
- Expected model (`exp_q`, `known`):
  - SET gives `exp_q`=1 and `known`=1. RESET gives `exp_q`=0 and `known`=1.
  - HOLD and DISABLE leave `exp_q` unchanged. If `known`=0 and the sample is complementary, `exp_q` takes the sampled Q and `known` becomes 1.
- Error rule: `rsp_err`=1 if `ff_result`==`ff_not_result`, or if `known`=1 before the command and sampled Q differs from the post-command `exp_q`.
- When `rsp_err`=1, `err_count` increments in CHECK, saturating at 2^CNT_W-1. The model is not updated from an erroneous sample; SET and RESET still define it.
- The set=1/reset=1 combination with the flip-flop enabled is never driven.

## Timing

- The flip-flop captures on the rising edge that ends DRIVE.
- Sampling happens in the cycle WAIT_CYCLES after DRIVE.
- `rsp_valid` rises WAIT_CYCLES+2 cycles after the accept edge.
- Minimum command period is WAIT_CYCLES+3 cycles, with `rsp_ready` held at 1.
- `cmd_ready` and `rsp_valid` are never both 1. There is no command buffering.
- `rsp_ready` held at 0 stalls RESP indefinitely. The ff_* outputs stay at idle values during the stall.
- `reset` asserted in any state: next cycle is IDLE with all reset values. The in-flight command is dropped and no response is produced. `reset` has priority over handshakes in the same cycle.
- `err_count` and `known` are cleared only by `reset`.

## Test plan

- Reset, then SET with `rsp_ready`=1 against a correct flip-flop model: `ff_set`=1 and `ff_clock_en`=0 for exactly 1 cycle. With WAIT_CYCLES=1, `rsp_valid` is 1 at cycle 3 after accept, with `rsp_q`=1, `rsp_err`=0 and `known`=1.
- Sequence SET, DISABLE, RESET, HOLD: `rsp_q` is 1, 1, 0, 0, all with `rsp_err`=0. During DISABLE, `ff_clock_en`=1, `ff_set`=1 and `ff_reset`=1.
- Flip-flop model forced to ignore RESET: after SET then RESET, the second response has `rsp_q`=1, `rsp_err`=1 and `err_count`=1.
- Drive `ff_result`=`ff_not_result`=1 on HOLD straight after reset: `rsp_err`=1 and `known` stays 0.
- Hold `rsp_ready`=0 for 10 cycles during RESP: `rsp_valid` stays 1, `cmd_ready` stays 0, and the response fields are stable. With `CNT_W`=2, four errors leave `err_count` at 3.
- Assert `reset` during SETTLE: the next cycle has `cmd_ready`=1, `rsp_valid`=0, `known`=0 and `err_count`=0, and no response ever appears for the dropped command.
